// File: rtl/pwr_seq_ctrl.sv
// Power-sequencing controller for a switchable retention domain: drives isolation,
// save/restore pulses, supply-switch enable and domain reset in a fixed order.
module pwr_seq_ctrl #(
   parameter int unsigned ISO_SETUP_CYC = 2,
   parameter int unsigned PWR_UP_CYC    = 4,
   parameter int unsigned RST_CYC       = 2,
   parameter int unsigned ISO_HOLD_CYC  = 1,
   parameter int unsigned CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pd_req,
   input  logic       pu_req,
   output logic       iso_enable,
   output logic       save,
   output logic       restore,
   output logic       pwr_en,
   output logic       dom_rst,
   output logic       busy,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_ON      = 3'd0,
      S_ISO     = 3'd1,
      S_SAVE    = 3'd2,
      S_OFF     = 3'd3,
      S_PWRUP   = 3'd4,
      S_RST     = 3'd5,
      S_RESTORE = 3'd6,
      S_UNISO   = 3'd7
   } state_t;

   typedef struct packed {
      logic iso;
      logic sv;
      logic rs;
      logic pwr;
      logic drst;
      logic bsy;
   } outs_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   outs_t            outs_q, outs_nxt;

   function automatic logic [CNT_W-1:0] load_cnt(input int unsigned n);
      return CNT_W'(n - 1);
   endfunction

   // Output table per state; registered from the next state so pins never glitch.
   function automatic outs_t decode(input state_t s);
      outs_t o;
      o = '{iso: 1'b1, sv: 1'b0, rs: 1'b0, pwr: 1'b1, drst: 1'b0, bsy: 1'b1};
      case (s)
         S_ON:      begin o.iso = 1'b0; o.bsy = 1'b0; end
         S_SAVE:    o.sv = 1'b1;
         S_OFF:     begin o.pwr = 1'b0; o.bsy = 1'b0; end
         S_PWRUP,
         S_RST:     o.drst = 1'b1;
         S_RESTORE: o.rs = 1'b1;
         default:   ;
      endcase
      return o;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_ON;
         cnt    <= '0;
         outs_q <= '{iso: 1'b0, sv: 1'b0, rs: 1'b0, pwr: 1'b1, drst: 1'b0, bsy: 1'b0};
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         outs_q <= outs_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_ON: if (pd_req) begin
            state_nxt = S_ISO;
            cnt_nxt   = load_cnt(ISO_SETUP_CYC);
         end
         S_ISO:
            if (cnt == '0) state_nxt = S_SAVE;
            else           cnt_nxt   = cnt - 1'b1;
         S_SAVE: state_nxt = S_OFF;
         S_OFF: if (pu_req) begin
            state_nxt = S_PWRUP;
            cnt_nxt   = load_cnt(PWR_UP_CYC);
         end
         S_PWRUP:
            if (cnt == '0) begin
               state_nxt = S_RST;
               cnt_nxt   = load_cnt(RST_CYC);
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         S_RST:
            if (cnt == '0) state_nxt = S_RESTORE;
            else           cnt_nxt   = cnt - 1'b1;
         S_RESTORE: begin
            state_nxt = S_UNISO;
            cnt_nxt   = load_cnt(ISO_HOLD_CYC);
         end
         S_UNISO:
            if (cnt == '0) state_nxt = S_ON;
            else           cnt_nxt   = cnt - 1'b1;
         default: state_nxt = S_ON;
      endcase
      outs_nxt = decode(state_nxt);
   end

   assign iso_enable = outs_q.iso;
   assign save       = outs_q.sv;
   assign restore    = outs_q.rs;
   assign pwr_en     = outs_q.pwr;
   assign dom_rst    = outs_q.drst;
   assign busy       = outs_q.bsy;
   assign state_o    = state;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Bench for pwr_seq_ctrl: default-parameter and short-timing instances run the same
// request stream against a duration-table reference model.
module tb_pwr_seq_ctrl;

   localparam int S_ON = 0, S_ISO = 1, S_SAVE = 2, S_OFF = 3;
   localparam int S_PWRUP = 4, S_RST = 5, S_RESTORE = 6, S_UNISO = 7;
   localparam int ISO_S [2] = '{2, 1};
   localparam int PU_S  [2] = '{4, 1};
   localparam int RS_S  [2] = '{2, 1};
   localparam int HOLD_S[2] = '{1, 3};

   logic clk = 1'b0, rst = 1'b1, pd_req = 1'b0, pu_req = 1'b0;
   logic       a_iso, a_save, a_restore, a_pwr, a_drst, a_busy;
   logic       b_iso, b_save, b_restore, b_pwr, b_drst, b_busy;
   logic [2:0] a_state, b_state;
   logic       a_pwr_prev = 1'b1, b_pwr_prev = 1'b1;

   int n_pass = 0, n_chk = 0;
   int ms[2], mrem[2];

   always #5 clk = ~clk;

   pwr_seq_ctrl dut_a (
      .clk(clk), .rst(rst), .pd_req(pd_req), .pu_req(pu_req),
      .iso_enable(a_iso), .save(a_save), .restore(a_restore), .pwr_en(a_pwr),
      .dom_rst(a_drst), .busy(a_busy), .state_o(a_state)
   );

   pwr_seq_ctrl #(.ISO_SETUP_CYC(1), .PWR_UP_CYC(1), .RST_CYC(1), .ISO_HOLD_CYC(3), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .pd_req(pd_req), .pu_req(pu_req),
      .iso_enable(b_iso), .save(b_save), .restore(b_restore), .pwr_en(b_pwr),
      .dom_rst(b_drst), .busy(b_busy), .state_o(b_state)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   function automatic int dur(input int i, input int s);
      case (s)
         S_ISO:   return ISO_S[i];
         S_PWRUP: return PU_S[i];
         S_RST:   return RS_S[i];
         S_UNISO: return HOLD_S[i];
         default: return 1;
      endcase
   endfunction

   function automatic int succ(input int s);
      case (s)
         S_ISO:     return S_SAVE;
         S_SAVE:    return S_OFF;
         S_PWRUP:   return S_RST;
         S_RST:     return S_RESTORE;
         S_RESTORE: return S_UNISO;
         S_UNISO:   return S_ON;
         default:   return s;
      endcase
   endfunction

   // {state, iso, save, restore, pwr_en, dom_rst, busy}
   function automatic logic [8:0] exp_outs(input int s);
      logic iso, sv, rs, pwr, drst, bsy;
      iso  = (s != S_ON);
      sv   = (s == S_SAVE);
      rs   = (s == S_RESTORE);
      pwr  = (s != S_OFF);
      drst = (s == S_PWRUP) || (s == S_RST);
      bsy  = (s != S_ON) && (s != S_OFF);
      return {3'(s), iso, sv, rs, pwr, drst, bsy};
   endfunction

   task automatic model_step(input int i, input bit pd, input bit pu);
      if (ms[i] == S_ON) begin
         if (pd) begin ms[i] = S_ISO; mrem[i] = dur(i, S_ISO); end
      end else if (ms[i] == S_OFF) begin
         if (pu) begin ms[i] = S_PWRUP; mrem[i] = dur(i, S_PWRUP); end
      end else if (mrem[i] > 1) begin
         mrem[i]--;
      end else begin
         ms[i]   = succ(ms[i]);
         mrem[i] = dur(i, ms[i]);
      end
   endtask

   task automatic compare_all();
      check_val("a_outs", {a_state, a_iso, a_save, a_restore, a_pwr, a_drst, a_busy}, exp_outs(ms[0]));
      check_val("b_outs", {b_state, b_iso, b_save, b_restore, b_pwr, b_drst, b_busy}, exp_outs(ms[1]));
      if (!b_pwr || b_save || b_restore) check_val("b_iso_clamp", b_iso, 1);
      if (!a_pwr || a_save || a_restore) check_val("a_iso_clamp", a_iso, 1);
      check_val("b_save_restore_excl", b_save & b_restore, 0);
      if (b_pwr_prev && !b_pwr) check_val("b_pwr_fall_vs_save", b_save, 0);
      if (a_pwr_prev && !a_pwr) check_val("a_pwr_fall_vs_save", a_save, 0);
      a_pwr_prev = a_pwr;
      b_pwr_prev = b_pwr;
   endtask

   task automatic tick(input bit pd, input bit pu);
      pd_req = pd;
      pu_req = pu;
      @(posedge clk);
      model_step(0, pd, pu);
      model_step(1, pd, pu);
      #1;
      compare_all();
   endtask

   task automatic model_reset();
      ms   = '{S_ON, S_ON};
      mrem = '{0, 0};
      a_pwr_prev = 1'b1;
      b_pwr_prev = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_outs_a", {a_state, a_iso, a_save, a_restore, a_pwr, a_drst, a_busy}, exp_outs(S_ON));
      check_val("reset_outs_b", {b_state, b_iso, b_save, b_restore, b_pwr, b_drst, b_busy}, exp_outs(S_ON));
      #4 rst = 1'b0;

      // Idle after reset release
      repeat (20) tick(0, 0);

      // Power-down pulse, edge-by-edge
      tick(1, 0);
      check_val("t2_iso_e0", a_iso, 1);
      tick(0, 0);
      check_val("t2_nosave_e1", a_save, 0);
      tick(0, 0);
      check_val("t2_save_e2", a_save, 1);
      check_val("t2_pwr_e2", a_pwr, 1);
      tick(0, 0);
      check_val("t2_save_off_e3", a_save, 0);
      check_val("t2_pwr_e3", a_pwr, 0);
      check_val("t2_state_e3", a_state, 3);
      repeat (3) tick(0, 0);

      // Power-up pulse from S_OFF
      tick(0, 1);
      for (int k = 0; k < 6; k++) begin
         check_val("t3_pwr_en", a_pwr, 1);
         check_val("t3_dom_rst", a_drst, 1);
         check_val("t3_no_restore", a_restore, 0);
         tick(0, 0);
      end
      check_val("t3_restore_e6", a_restore, 1);
      check_val("t3_dom_rst_e6", a_drst, 0);
      tick(0, 0);
      check_val("t3_restore_e7", a_restore, 0);
      check_val("t3_iso_e7", a_iso, 1);
      tick(0, 0);
      check_val("t3_iso_e8", a_iso, 0);
      check_val("t3_state_e8", a_state, 0);
      repeat (2) tick(0, 0);

      // Held pd_req with stray pu_req during isolation, then pd_req during ramp
      tick(1, 0);
      tick(1, 1);
      tick(1, 0);
      tick(1, 0);
      check_val("t4_state_off", a_state, 3);
      check_val("t4_pwr_off", a_pwr, 0);
      tick(0, 1);
      tick(1, 0);
      repeat (7) tick(0, 0);
      check_val("t4_back_on", a_state, 0);
      check_val("t4_iso_off", a_iso, 0);

      // Async reset in the middle of S_RST
      tick(1, 0);
      repeat (3) tick(0, 0);
      tick(0, 1);
      for (int i = 0; i < 20 && a_state != 3'd5; i++) tick(0, 0);
      check_val("t5_reach_rst", a_state, 5);
      #2 rst = 1'b1;
      #1;
      check_val("t5_async_outs_a", {a_state, a_iso, a_save, a_restore, a_pwr, a_drst, a_busy}, exp_outs(S_ON));
      check_val("t5_async_outs_b", {b_state, b_iso, b_save, b_restore, b_pwr, b_drst, b_busy}, exp_outs(S_ON));
      model_reset();
      #3 rst = 1'b0;
      tick(1, 0);
      repeat (3) tick(0, 0);
      check_val("t5_pd_after_rst", a_state, 3);

      // Random request sweep
      for (int i = 0; i < 3000; i++)
         tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
